// File: rtl/axil_reg_slave.sv
// AXI4-Lite slave with four 32-bit byte-strobed registers, exported contents and write pulses.
// Optional AXIL_REG_SLAVE_SLVERR_EN: addresses with ADDR[AW-1:4] != 0 answer SLVERR and have no effect.
module axil_reg_slave #(
    parameter int unsigned C_S_AXI_DATA_WIDTH = 32,
    parameter int unsigned C_S_AXI_ADDR_WIDTH = 6
) (
    input  logic                              S_AXI_ACLK,
    input  logic                              S_AXI_ARESET,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]     S_AXI_AWADDR,
    input  logic [2:0]                        S_AXI_AWPROT,
    input  logic                              S_AXI_AWVALID,
    output logic                              S_AXI_AWREADY,
    input  logic [C_S_AXI_DATA_WIDTH-1:0]     S_AXI_WDATA,
    input  logic [C_S_AXI_DATA_WIDTH/8-1:0]   S_AXI_WSTRB,
    input  logic                              S_AXI_WVALID,
    output logic                              S_AXI_WREADY,
    output logic [1:0]                        S_AXI_BRESP,
    output logic                              S_AXI_BVALID,
    input  logic                              S_AXI_BREADY,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]     S_AXI_ARADDR,
    input  logic [2:0]                        S_AXI_ARPROT,
    input  logic                              S_AXI_ARVALID,
    output logic                              S_AXI_ARREADY,
    output logic [C_S_AXI_DATA_WIDTH-1:0]     S_AXI_RDATA,
    output logic [1:0]                        S_AXI_RRESP,
    output logic                              S_AXI_RVALID,
    input  logic                              S_AXI_RREADY,
    output logic [4*C_S_AXI_DATA_WIDTH-1:0]   reg_out,
    output logic [3:0]                        wr_pulse
);

    localparam int unsigned DW   = C_S_AXI_DATA_WIDTH;
    localparam int unsigned AW   = C_S_AXI_ADDR_WIDTH;
    localparam int unsigned SW   = DW / 8;
    localparam int unsigned NREG = 4;
    localparam logic [1:0]  RESP_OKAY   = 2'b00;
    localparam logic [1:0]  RESP_SLVERR = 2'b10;

    typedef enum logic [1:0] {W_IDLE, W_HAVE_AW, W_HAVE_W, W_RESP} wstate_t;
    typedef enum logic {R_IDLE, R_DATA} rstate_t;

    wstate_t                   wstate, wstate_nxt;
    rstate_t                   rstate, rstate_nxt;
    logic [NREG-1:0][DW-1:0]   regs, regs_nxt;
    logic [AW-1:0]             awaddr_q, awaddr_nxt;
    logic [DW-1:0]             wdata_q, wdata_nxt;
    logic [SW-1:0]             wstrb_q, wstrb_nxt;
    logic                      awready_nxt, wready_nxt, bvalid_nxt;
    logic [1:0]                bresp_nxt, rresp_nxt;
    logic [NREG-1:0]           wr_pulse_nxt;
    logic                      arready_nxt, rvalid_nxt;
    logic [DW-1:0]             rdata_nxt;

    logic                      aw_hs, w_hs, ar_hs, commit, c_err, r_err;
    logic [AW-1:0]             c_addr;
    logic [DW-1:0]             c_data;
    logic [SW-1:0]             c_strb;
    logic [1:0]                c_idx;
    logic                      unused_ok;

    assign aw_hs   = S_AXI_AWVALID & S_AXI_AWREADY;
    assign w_hs    = S_AXI_WVALID & S_AXI_WREADY;
    assign ar_hs   = S_AXI_ARVALID & S_AXI_ARREADY;
    assign reg_out = regs;
    assign unused_ok = ^{S_AXI_AWPROT, S_AXI_ARPROT, S_AXI_AWADDR, S_AXI_ARADDR, awaddr_q};

    // Write channel: gather AW and W in either order, commit on the edge entering W_RESP
    always_comb begin
        wstate_nxt   = wstate;
        awaddr_nxt   = awaddr_q;
        wdata_nxt    = wdata_q;
        wstrb_nxt    = wstrb_q;
        regs_nxt     = regs;
        bresp_nxt    = S_AXI_BRESP;
        wr_pulse_nxt = '0;
        commit       = 1'b0;
        c_addr       = S_AXI_AWADDR;
        c_data       = S_AXI_WDATA;
        c_strb       = S_AXI_WSTRB;
        case (wstate)
            W_IDLE: begin
                if (aw_hs && w_hs) begin
                    commit = 1'b1;
                end else if (aw_hs) begin
                    wstate_nxt = W_HAVE_AW;
                    awaddr_nxt = S_AXI_AWADDR;
                end else if (w_hs) begin
                    wstate_nxt = W_HAVE_W;
                    wdata_nxt  = S_AXI_WDATA;
                    wstrb_nxt  = S_AXI_WSTRB;
                end
            end
            W_HAVE_AW: begin
                c_addr = awaddr_q;
                commit = w_hs;
            end
            W_HAVE_W: begin
                c_data = wdata_q;
                c_strb = wstrb_q;
                commit = aw_hs;
            end
            W_RESP: begin
                if (S_AXI_BREADY) wstate_nxt = W_IDLE;
            end
            default: wstate_nxt = W_IDLE;
        endcase
        c_idx = c_addr[3:2];
        c_err = 1'b0;
`ifdef AXIL_REG_SLAVE_SLVERR_EN
        c_err = (c_addr >> 4) != '0;
`endif
        if (commit) begin
            wstate_nxt = W_RESP;
            bresp_nxt  = c_err ? RESP_SLVERR : RESP_OKAY;
            if (!c_err) begin
                for (int unsigned b = 0; b < SW; b++) begin
                    if (c_strb[b]) regs_nxt[c_idx][b*8 +: 8] = c_data[b*8 +: 8];
                end
                if (c_strb != '0) wr_pulse_nxt[c_idx] = 1'b1;
            end
        end
        awready_nxt = (wstate_nxt == W_IDLE) || (wstate_nxt == W_HAVE_W);
        wready_nxt  = (wstate_nxt == W_IDLE) || (wstate_nxt == W_HAVE_AW);
        bvalid_nxt  = (wstate_nxt == W_RESP);
    end

    // Read channel: capture data from the current register state, so a same-edge write reads old
    always_comb begin
        rstate_nxt = rstate;
        rdata_nxt  = S_AXI_RDATA;
        rresp_nxt  = S_AXI_RRESP;
        r_err      = 1'b0;
`ifdef AXIL_REG_SLAVE_SLVERR_EN
        r_err      = (S_AXI_ARADDR >> 4) != '0;
`endif
        case (rstate)
            R_IDLE: begin
                if (ar_hs) begin
                    rstate_nxt = R_DATA;
                    rdata_nxt  = r_err ? '0 : regs[S_AXI_ARADDR[3:2]];
                    rresp_nxt  = r_err ? RESP_SLVERR : RESP_OKAY;
                end
            end
            R_DATA: begin
                if (S_AXI_RREADY) rstate_nxt = R_IDLE;
            end
            default: rstate_nxt = R_IDLE;
        endcase
        arready_nxt = (rstate_nxt == R_IDLE);
        rvalid_nxt  = (rstate_nxt == R_DATA);
    end

    // READYs stay low through reset and rise on the first edge after release
    always_ff @(posedge S_AXI_ACLK or posedge S_AXI_ARESET) begin
        if (S_AXI_ARESET) begin
            wstate        <= W_IDLE;
            rstate        <= R_IDLE;
            regs          <= '0;
            awaddr_q      <= '0;
            wdata_q       <= '0;
            wstrb_q       <= '0;
            S_AXI_AWREADY <= 1'b0;
            S_AXI_WREADY  <= 1'b0;
            S_AXI_BVALID  <= 1'b0;
            S_AXI_BRESP   <= RESP_OKAY;
            wr_pulse      <= '0;
            S_AXI_ARREADY <= 1'b0;
            S_AXI_RVALID  <= 1'b0;
            S_AXI_RDATA   <= '0;
            S_AXI_RRESP   <= RESP_OKAY;
        end else begin
            wstate        <= wstate_nxt;
            rstate        <= rstate_nxt;
            regs          <= regs_nxt;
            awaddr_q      <= awaddr_nxt;
            wdata_q       <= wdata_nxt;
            wstrb_q       <= wstrb_nxt;
            S_AXI_AWREADY <= awready_nxt;
            S_AXI_WREADY  <= wready_nxt;
            S_AXI_BVALID  <= bvalid_nxt;
            S_AXI_BRESP   <= bresp_nxt;
            wr_pulse      <= wr_pulse_nxt;
            S_AXI_ARREADY <= arready_nxt;
            S_AXI_RVALID  <= rvalid_nxt;
            S_AXI_RDATA   <= rdata_nxt;
            S_AXI_RRESP   <= rresp_nxt;
        end
    end

endmodule

// File: tb/tb_axil_reg_slave.sv
// Self-checking bench for axil_reg_slave: directed scenarios plus randomized traffic against a register model.
module tb_axil_reg_slave;

    logic         clk;
    logic         rst;
    logic [5:0]   awaddr, araddr;
    logic [2:0]   awprot, arprot;
    logic         awvalid, awready, wvalid, wready, bvalid, bready;
    logic         arvalid, arready, rvalid, rready;
    logic [31:0]  wdata, rdata;
    logic [3:0]   wstrb, wr_pulse;
    logic [1:0]   bresp, rresp;
    logic [127:0] reg_out;

    int errors;
    int checks;
    logic [31:0] model [4];

`ifdef AXIL_REG_SLAVE_SLVERR_EN
    localparam bit SLVERR_EN = 1'b1;
`else
    localparam bit SLVERR_EN = 1'b0;
`endif

    axil_reg_slave #(.C_S_AXI_DATA_WIDTH(32), .C_S_AXI_ADDR_WIDTH(6)) dut (
        .S_AXI_ACLK(clk),       .S_AXI_ARESET(rst),
        .S_AXI_AWADDR(awaddr),  .S_AXI_AWPROT(awprot),  .S_AXI_AWVALID(awvalid), .S_AXI_AWREADY(awready),
        .S_AXI_WDATA(wdata),    .S_AXI_WSTRB(wstrb),    .S_AXI_WVALID(wvalid),   .S_AXI_WREADY(wready),
        .S_AXI_BRESP(bresp),    .S_AXI_BVALID(bvalid),  .S_AXI_BREADY(bready),
        .S_AXI_ARADDR(araddr),  .S_AXI_ARPROT(arprot),  .S_AXI_ARVALID(arvalid), .S_AXI_ARREADY(arready),
        .S_AXI_RDATA(rdata),    .S_AXI_RRESP(rresp),    .S_AXI_RVALID(rvalid),   .S_AXI_RREADY(rready),
        .reg_out(reg_out),      .wr_pulse(wr_pulse)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog simulation did not finish");
        $fatal(1);
    end

    // Reference model: addresses alias modulo 16, 4 bytes per register
    function automatic bit m_err(input logic [5:0] a);
        return SLVERR_EN && (a >= 6'd16);
    endfunction

    function automatic int m_idx(input logic [5:0] a);
        return int'(a % 6'd16) / 4;
    endfunction

    function automatic void m_clear();
        for (int i = 0; i < 4; i++) model[i] = 32'h0;
    endfunction

    function automatic void m_write(input logic [5:0] a, input logic [31:0] d, input logic [3:0] s);
        logic [31:0] mask;
        mask = 32'h0;
        for (int b = 0; b < 4; b++) if (s[b]) mask = mask | (32'hFF << (8 * b));
        if (!m_err(a)) model[m_idx(a)] = (model[m_idx(a)] & ~mask) | (d & mask);
    endfunction

    function automatic logic [31:0] m_read(input logic [5:0] a);
        return m_err(a) ? 32'h0 : model[m_idx(a)];
    endfunction

    function automatic logic [1:0] m_resp(input logic [5:0] a);
        return m_err(a) ? 2'b10 : 2'b00;
    endfunction

    function automatic logic [3:0] m_pulse(input logic [5:0] a, input logic [3:0] s);
        return (m_err(a) || s == 4'h0) ? 4'h0 : 4'(1 << m_idx(a));
    endfunction

    function automatic logic [127:0] m_regs();
        return {model[3], model[2], model[1], model[0]};
    endfunction

    // Drives one write with independent AW/W start delays and BREADY high
    task automatic axi_write(input logic [5:0] a, input logic [31:0] d, input logic [3:0] s,
                             input int aw_dly, input int w_dly,
                             output logic [1:0] resp, output logic [3:0] pulse_or,
                             output int pulse_cnt, output int lat, output bit tmo);
        bit aw_done, w_done;
        int n;
        aw_done = 1'b0; w_done = 1'b0; n = 0; tmo = 1'b0;
        pulse_or = 4'h0; pulse_cnt = 0; lat = 0; resp = 2'b11;
        awaddr = a; wdata = d; wstrb = s; bready = 1'b1;
        awprot = 3'($urandom_range(0, 7));
        while (!(aw_done && w_done) && n < 100) begin
            awvalid = !aw_done && (n >= aw_dly);
            wvalid  = !w_done && (n >= w_dly);
            if (awvalid && awready) aw_done = 1'b1;
            if (wvalid && wready) w_done = 1'b1;
            @(posedge clk); #1; n++;
            if (wr_pulse != 4'h0) begin pulse_or = pulse_or | wr_pulse; pulse_cnt++; end
        end
        awvalid = 1'b0; wvalid = 1'b0;
        while (!bvalid && lat < 100) begin
            @(posedge clk); #1; lat++;
            if (wr_pulse != 4'h0) begin pulse_or = pulse_or | wr_pulse; pulse_cnt++; end
        end
        tmo  = !bvalid || !(aw_done && w_done);
        resp = bresp;
        @(posedge clk); #1;
        if (wr_pulse != 4'h0) begin pulse_or = pulse_or | wr_pulse; pulse_cnt++; end
        bready = 1'b0;
    endtask

    task automatic axi_read(input logic [5:0] a, input int ar_dly,
                            output logic [31:0] d, output logic [1:0] resp, output int lat, output bit tmo);
        bit done;
        int n;
        done = 1'b0; n = 0; lat = 0;
        araddr = a; rready = 1'b1; arprot = 3'($urandom_range(0, 7));
        while (!done && n < 100) begin
            arvalid = (n >= ar_dly);
            if (arvalid && arready) done = 1'b1;
            @(posedge clk); #1; n++;
        end
        arvalid = 1'b0;
        while (!rvalid && lat < 100) begin @(posedge clk); #1; lat++; end
        tmo = !rvalid || !done;
        d = rdata; resp = rresp;
        @(posedge clk); #1;
        rready = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        awvalid = 0; wvalid = 0; arvalid = 0; bready = 0; rready = 0;
        awaddr = 0; araddr = 0; wdata = 0; wstrb = 0; awprot = 0; arprot = 0;
        m_clear();
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if ({awready, wready, arready, bvalid, rvalid} !== 5'b0) begin
            errors++; $display("FAIL reset_handshake got=%b exp=%b", {awready, wready, arready, bvalid, rvalid}, 5'b0);
        end
        checks++;
        if (reg_out !== 128'h0 || wr_pulse !== 4'h0 || rdata !== 32'h0 || bresp !== 2'b00 || rresp !== 2'b00) begin
            errors++; $display("FAIL reset_values regs=%h pulse=%b rdata=%h bresp=%b rresp=%b exp all zero",
                               reg_out, wr_pulse, rdata, bresp, rresp);
        end
        rst = 1'b0; #1;
        checks++;
        if ({awready, wready, arready} !== 3'b000) begin
            errors++; $display("FAIL reset_ready_early got=%b exp=%b", {awready, wready, arready}, 3'b000);
        end
        @(posedge clk); #1;
        checks++;
        if ({awready, wready, arready} !== 3'b111) begin
            errors++; $display("FAIL reset_ready_rise got=%b exp=%b", {awready, wready, arready}, 3'b111);
        end
    endtask

    task automatic test_basic();
        logic [1:0] resp; logic [3:0] por; int pcnt, lat; bit tmo; logic [31:0] d;
        for (int i = 0; i < 4; i++) begin
            logic [5:0] a;
            a = 6'(4 * i);
            axi_write(a, 32'(i + 1), 4'hF, 0, 0, resp, por, pcnt, lat, tmo);
            m_write(a, 32'(i + 1), 4'hF);
            checks++;
            if (tmo !== 1'b0 || lat !== 0 || resp !== 2'b00) begin
                errors++; $display("FAIL basic_wr[%0d] tmo=%0d lat=%0d resp=%b exp tmo=0 lat=0 resp=00", i, tmo, lat, resp);
            end
            checks++;
            if (pcnt !== 1 || por !== 4'(1 << i)) begin
                errors++; $display("FAIL basic_pulse[%0d] cycles=%0d mask=%b exp cycles=1 mask=%b", i, pcnt, por, 4'(1 << i));
            end
        end
        checks++;
        if (reg_out !== m_regs()) begin
            errors++; $display("FAIL basic_regs got=%h exp=%h", reg_out, m_regs());
        end
        for (int i = 0; i < 4; i++) begin
            axi_read(6'(4 * i), 0, d, resp, lat, tmo);
            checks++;
            if (tmo !== 1'b0 || lat !== 0 || resp !== 2'b00 || d !== 32'(i + 1)) begin
                errors++; $display("FAIL basic_rd[%0d] tmo=%0d lat=%0d resp=%b data=%h exp data=%h", i, tmo, lat, resp, d, 32'(i + 1));
            end
        end
    endtask

    task automatic test_w_before_aw();
        awvalid = 1'b0; wvalid = 1'b1; wdata = 32'hA5A5A5A5; wstrb = 4'hF; bready = 1'b1;
        @(posedge clk); #1;
        wvalid = 1'b0;
        checks++;
        if (wready !== 1'b0 || awready !== 1'b1 || bvalid !== 1'b0) begin
            errors++; $display("FAIL wfirst_after_w wready=%b awready=%b bvalid=%b exp 0 1 0", wready, awready, bvalid);
        end
        repeat (2) begin
            @(posedge clk); #1;
            checks++;
            if (wready !== 1'b0 || bvalid !== 1'b0) begin
                errors++; $display("FAIL wfirst_wait wready=%b bvalid=%b exp 0 0", wready, bvalid);
            end
        end
        awvalid = 1'b1; awaddr = 6'h08;
        @(posedge clk); #1;
        awvalid = 1'b0;
        m_write(6'h08, 32'hA5A5A5A5, 4'hF);
        checks++;
        if (bvalid !== 1'b1 || bresp !== 2'b00 || reg_out[95:64] !== 32'hA5A5A5A5 || wr_pulse !== 4'b0100) begin
            errors++; $display("FAIL wfirst_commit bvalid=%b bresp=%b reg2=%h pulse=%b exp 1 00 a5a5a5a5 0100",
                               bvalid, bresp, reg_out[95:64], wr_pulse);
        end
        @(posedge clk); #1;
        bready = 1'b0;
        checks++;
        if (bvalid !== 1'b0 || wr_pulse !== 4'h0 || awready !== 1'b1 || wready !== 1'b1) begin
            errors++; $display("FAIL wfirst_done bvalid=%b pulse=%b awready=%b wready=%b exp 0 0000 1 1",
                               bvalid, wr_pulse, awready, wready);
        end
    endtask

    task automatic test_strobe();
        logic [1:0] resp; logic [3:0] por; int pcnt, lat; bit tmo;
        axi_write(6'h04, 32'h11223344, 4'hF, 0, 1, resp, por, pcnt, lat, tmo);
        m_write(6'h04, 32'h11223344, 4'hF);
        axi_write(6'h04, 32'hFFFFFFFF, 4'b0101, 1, 0, resp, por, pcnt, lat, tmo);
        m_write(6'h04, 32'hFFFFFFFF, 4'b0101);
        checks++;
        if (reg_out[63:32] !== 32'h11FF33FF || resp !== 2'b00 || por !== 4'b0010) begin
            errors++; $display("FAIL strobe_partial reg1=%h resp=%b pulse=%b exp 11ff33ff 00 0010", reg_out[63:32], resp, por);
        end
        axi_write(6'h04, 32'h0, 4'h0, 0, 0, resp, por, pcnt, lat, tmo);
        checks++;
        if (reg_out !== m_regs() || resp !== 2'b00 || pcnt !== 0 || tmo !== 1'b0) begin
            errors++; $display("FAIL strobe_zero regs=%h resp=%b pulses=%0d exp regs=%h resp=00 pulses=0",
                               reg_out, resp, pcnt, m_regs());
        end
    endtask

    task automatic test_backpressure();
        logic [31:0] exp_d;
        awaddr = 6'h0C; wdata = 32'hCAFEF00D; wstrb = 4'hF; awvalid = 1'b1; wvalid = 1'b1; bready = 1'b0;
        @(posedge clk); #1;
        m_write(6'h0C, 32'hCAFEF00D, 4'hF);
        awaddr = 6'h00; wdata = 32'h0BAD0BAD;
        for (int i = 0; i < 10; i++) begin
            checks++;
            if (bvalid !== 1'b1 || bresp !== 2'b00 || awready !== 1'b0 || wready !== 1'b0 || reg_out !== m_regs()) begin
                errors++; $display("FAIL bp_write[%0d] bvalid=%b bresp=%b awready=%b wready=%b regs=%h exp 1 00 0 0 %h",
                                   i, bvalid, bresp, awready, wready, reg_out, m_regs());
            end
            @(posedge clk); #1;
        end
        awvalid = 1'b0; wvalid = 1'b0; bready = 1'b1;
        @(posedge clk); #1;
        bready = 1'b0;
        checks++;
        if (bvalid !== 1'b0 || awready !== 1'b1 || wready !== 1'b1 || reg_out !== m_regs()) begin
            errors++; $display("FAIL bp_write_release bvalid=%b awready=%b wready=%b exp 0 1 1", bvalid, awready, wready);
        end
        exp_d = m_read(6'h0C);
        araddr = 6'h0C; arvalid = 1'b1; rready = 1'b0;
        @(posedge clk); #1;
        araddr = 6'h00;
        for (int i = 0; i < 10; i++) begin
            checks++;
            if (rvalid !== 1'b1 || rdata !== exp_d || rresp !== 2'b00 || arready !== 1'b0) begin
                errors++; $display("FAIL bp_read[%0d] rvalid=%b rdata=%h rresp=%b arready=%b exp 1 %h 00 0",
                                   i, rvalid, rdata, rresp, arready, exp_d);
            end
            @(posedge clk); #1;
        end
        arvalid = 1'b0; rready = 1'b1;
        @(posedge clk); #1;
        rready = 1'b0;
        checks++;
        if (rvalid !== 1'b0 || arready !== 1'b1) begin
            errors++; $display("FAIL bp_read_release rvalid=%b arready=%b exp 0 1", rvalid, arready);
        end
    endtask

    task automatic test_read_write_collision();
        logic [31:0] old_v, d; logic [1:0] resp; int lat; bit tmo;
        old_v = m_read(6'h00);
        awaddr = 6'h00; wdata = 32'h0000DEAD; wstrb = 4'hF; araddr = 6'h00;
        awvalid = 1'b1; wvalid = 1'b1; arvalid = 1'b1; bready = 1'b1; rready = 1'b1;
        @(posedge clk); #1;
        awvalid = 1'b0; wvalid = 1'b0; arvalid = 1'b0;
        m_write(6'h00, 32'h0000DEAD, 4'hF);
        checks++;
        if (rvalid !== 1'b1 || rdata !== old_v || bvalid !== 1'b1) begin
            errors++; $display("FAIL collide_read_old rvalid=%b rdata=%h bvalid=%b exp 1 %h 1", rvalid, rdata, bvalid, old_v);
        end
        @(posedge clk); #1;
        bready = 1'b0; rready = 1'b0;
        axi_read(6'h00, 1, d, resp, lat, tmo);
        checks++;
        if (d !== 32'h0000DEAD || resp !== 2'b00 || tmo !== 1'b0) begin
            errors++; $display("FAIL collide_read_new data=%h resp=%b tmo=%0d exp 0000dead 00 0", d, resp, tmo);
        end
    endtask

    task automatic test_upper_addr();
        logic [1:0] resp; logic [3:0] por; int pcnt, lat; bit tmo; logic [31:0] d;
        axi_write(6'h20, 32'h5A5A1234, 4'hF, 0, 0, resp, por, pcnt, lat, tmo);
        checks++;
        if (resp !== m_resp(6'h20) || por !== m_pulse(6'h20, 4'hF)) begin
            errors++; $display("FAIL upper_wr resp=%b pulse=%b exp %b %b", resp, por, m_resp(6'h20), m_pulse(6'h20, 4'hF));
        end
        m_write(6'h20, 32'h5A5A1234, 4'hF);
        checks++;
        if (reg_out !== m_regs()) begin
            errors++; $display("FAIL upper_regs got=%h exp=%h", reg_out, m_regs());
        end
        axi_read(6'h20, 0, d, resp, lat, tmo);
        checks++;
        if (d !== m_read(6'h20) || resp !== m_resp(6'h20) || tmo !== 1'b0) begin
            errors++; $display("FAIL upper_rd data=%h resp=%b exp %h %b", d, resp, m_read(6'h20), m_resp(6'h20));
        end
        axi_read(6'h03, 0, d, resp, lat, tmo);
        checks++;
        if (d !== m_read(6'h03) || resp !== 2'b00) begin
            errors++; $display("FAIL lowbits_rd data=%h resp=%b exp %h 00", d, resp, m_read(6'h03));
        end
    endtask

    task automatic test_random();
        logic [1:0] resp; logic [3:0] por; int pcnt, lat; bit tmo; logic [31:0] d;
        for (int i = 0; i < 60; i++) begin
            logic [5:0] a; logic [31:0] wd; logic [3:0] s;
            a  = ($urandom_range(0, 3) == 0) ? 6'($urandom_range(0, 63)) : 6'($urandom_range(0, 15));
            wd = $urandom;
            s  = 4'($urandom_range(0, 15));
            if ($urandom_range(0, 1) == 1) begin
                axi_write(a, wd, s, $urandom_range(0, 3), $urandom_range(0, 3), resp, por, pcnt, lat, tmo);
                checks++;
                if (tmo !== 1'b0 || lat !== 0 || resp !== m_resp(a) || por !== m_pulse(a, s) ||
                    pcnt !== ((m_pulse(a, s) != 4'h0) ? 1 : 0)) begin
                    errors++; $display("FAIL rand_wr[%0d] a=%h s=%b tmo=%0d lat=%0d resp=%b pulse=%b/%0d exp resp=%b pulse=%b",
                                       i, a, s, tmo, lat, resp, por, pcnt, m_resp(a), m_pulse(a, s));
                end
                m_write(a, wd, s);
                checks++;
                if (reg_out !== m_regs()) begin
                    errors++; $display("FAIL rand_regs[%0d] got=%h exp=%h", i, reg_out, m_regs());
                end
            end else begin
                axi_read(a, $urandom_range(0, 3), d, resp, lat, tmo);
                checks++;
                if (tmo !== 1'b0 || lat !== 0 || d !== m_read(a) || resp !== m_resp(a)) begin
                    errors++; $display("FAIL rand_rd[%0d] a=%h tmo=%0d lat=%0d data=%h resp=%b exp %h %b",
                                       i, a, tmo, lat, d, resp, m_read(a), m_resp(a));
                end
            end
        end
    endtask

    task automatic test_reset_mid();
        logic [31:0] d; logic [1:0] resp; int lat; bit tmo;
        awaddr = 6'h08; wdata = 32'h77777777; wstrb = 4'hF; araddr = 6'h04;
        awvalid = 1'b1; wvalid = 1'b1; arvalid = 1'b1; bready = 1'b0; rready = 1'b0;
        @(posedge clk); #1;
        awvalid = 1'b0; wvalid = 1'b0; arvalid = 1'b0;
        checks++;
        if (bvalid !== 1'b1 || rvalid !== 1'b1) begin
            errors++; $display("FAIL rstmid_pending bvalid=%b rvalid=%b exp 1 1", bvalid, rvalid);
        end
        #2 rst = 1'b1;
        #1;
        m_clear();
        checks++;
        if (bvalid !== 1'b0 || rvalid !== 1'b0 || reg_out !== 128'h0 || {awready, wready, arready} !== 3'b000) begin
            errors++; $display("FAIL rstmid_async bvalid=%b rvalid=%b regs=%h readys=%b exp 0 0 0 000",
                               bvalid, rvalid, reg_out, {awready, wready, arready});
        end
        @(posedge clk); #2;
        rst = 1'b0; #1;
        checks++;
        if ({awready, wready, arready} !== 3'b000) begin
            errors++; $display("FAIL rstmid_ready_early got=%b exp=000", {awready, wready, arready});
        end
        @(posedge clk); #1;
        checks++;
        if ({awready, wready, arready} !== 3'b111) begin
            errors++; $display("FAIL rstmid_ready_rise got=%b exp=111", {awready, wready, arready});
        end
        repeat (3) begin
            @(posedge clk); #1;
            checks++;
            if (bvalid !== 1'b0 || rvalid !== 1'b0 || wr_pulse !== 4'h0) begin
                errors++; $display("FAIL rstmid_no_beat bvalid=%b rvalid=%b pulse=%b exp 0 0 0000", bvalid, rvalid, wr_pulse);
            end
        end
        axi_read(6'h08, 0, d, resp, lat, tmo);
        checks++;
        if (d !== 32'h0 || resp !== 2'b00 || tmo !== 1'b0) begin
            errors++; $display("FAIL rstmid_cleared data=%h resp=%b exp 00000000 00", d, resp);
        end
    endtask

    initial begin
        errors = 0;
        checks = 0;
        test_reset();
        test_basic();
        test_w_before_aw();
        test_strobe();
        test_backpressure();
        test_read_write_collision();
        test_upper_addr();
        test_random();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
